// File: rtl/counter_nbit_if.sv
// counter_nbit_if: control and status bundle for counter_nbit.
//   en, up_dn, load, load_val, clr_ovf : controls driven by the master
//   q, q_gray, tc, bnd, ovf            : counter status returned by the slave
interface counter_nbit_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_gray;
  logic             tc;
  logic             bnd;
  logic             ovf;

  modport master (
    output en, up_dn, load, load_val, clr_ovf,
    input  q, q_gray, tc, bnd, ovf
  );

  modport slave (
    input  en, up_dn, load, load_val, clr_ovf,
    output q, q_gray, tc, bnd, ovf
  );

endinterface

// File: rtl/counter_nbit.sv
// counter_nbit: loadable up/down counter with a programmable terminal count,
// wrap or saturate behaviour at the boundaries, a Gray-code image of the count,
// a one-cycle boundary pulse and a sticky boundary flag.
// Ports:
//   clk   : clock, all state changes on its rising edge
//   reset : synchronous active-high reset
//   bus   : counter_nbit_if.slave
//             en/up_dn   count enable and direction (1 = up)
//             load/load_val parallel load, clamped to MAX_COUNT
//             clr_ovf    clears the sticky ovf flag
//             q, q_gray  registered count and its Gray image
//             tc         combinational terminal-count flag
//             bnd, ovf   registered boundary pulse and sticky boundary flag
module counter_nbit #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << WIDTH) - 32'd1),
  parameter bit          SATURATE  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  counter_nbit_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO_Q = '0;
  localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] gray_r;
  logic             bnd_r;
  logic             ovf_r;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] load_clamped;
  logic             at_top;
  logic             at_bottom;
  logic             tc_c;
  logic             hit;
  logic             ovf_next;

  // Boundary detection on the current count.
  always_comb begin
    at_top    = (q_r == MAX_Q);
    at_bottom = (q_r == ZERO_Q);
  end

  // tc ignores load; a real boundary hit additionally needs load low.
  always_comb begin
    tc_c = bus.en & ((bus.up_dn & at_top) | (~bus.up_dn & at_bottom));
    hit  = tc_c & ~bus.load;
  end

  // Loaded values above the terminal count are clamped so q never exceeds it.
  always_comb begin
    load_clamped = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
  end

  // Next count: load beats count; at a boundary either wrap or hold.
  always_comb begin
    q_next = q_r;
    if (bus.load) begin
      q_next = load_clamped;
    end else if (bus.en) begin
      if (hit) begin
        if (SATURATE) begin
          q_next = q_r;
        end else begin
          q_next = bus.up_dn ? ZERO_Q : MAX_Q;
        end
      end else if (bus.up_dn) begin
        q_next = q_r + ONE_Q;
      end else begin
        q_next = q_r - ONE_Q;
      end
    end
  end

  // Gray image is taken from the next count so it registers alongside q.
  always_comb begin
    gray_next = q_next ^ (q_next >> 1);
  end

  // A boundary hit in the same cycle as clr_ovf keeps the flag set.
  always_comb begin
    ovf_next = hit | (ovf_r & ~bus.clr_ovf);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= '0;
      gray_r <= '0;
      bnd_r  <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      q_r    <= q_next;
      gray_r <= gray_next;
      bnd_r  <= hit;
      ovf_r  <= ovf_next;
    end
  end

  assign bus.q      = q_r;
  assign bus.q_gray = gray_r;
  assign bus.tc     = tc_c;
  assign bus.bnd    = bnd_r;
  assign bus.ovf    = ovf_r;

endmodule

// File: tb/tb_counter_nbit.sv
// tb_counter_nbit: self-checking bench for counter_nbit.
// Three instances share one stimulus stream:
//   u0 : WIDTH=4, MAX_COUNT=9, wrap
//   u1 : WIDTH=4, MAX_COUNT=9, saturate
//   u2 : WIDTH=3, MAX_COUNT=7, wrap (full range, Gray checks)
// A modular-arithmetic model predicts every output each cycle; directed
// sequences add literal expectations, followed by a randomized phase.
module tb_counter_nbit;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic       clr_ovf;

  int total;
  int bad;

  counter_nbit_if #(.WIDTH(4)) if0 ();
  counter_nbit_if #(.WIDTH(4)) if1 ();
  counter_nbit_if #(.WIDTH(3)) if2 ();

  assign if0.en = en;  assign if0.up_dn = up_dn;  assign if0.load = load;
  assign if0.load_val = load_val;  assign if0.clr_ovf = clr_ovf;
  assign if1.en = en;  assign if1.up_dn = up_dn;  assign if1.load = load;
  assign if1.load_val = load_val;  assign if1.clr_ovf = clr_ovf;
  assign if2.en = en;  assign if2.up_dn = up_dn;  assign if2.load = load;
  assign if2.load_val = load_val[2:0];  assign if2.clr_ovf = clr_ovf;

  counter_nbit #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u0 (
    .clk(clk), .reset(reset), .bus(if0));
  counter_nbit #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(reset), .bus(if1));
  counter_nbit #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset(reset), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int mq[3];
  int mb[3];
  int mo[3];
  bit mvalid = 1'b0;

  function automatic int mx(input int i);
    return (i == 2) ? 7 : 9;
  endfunction

  function automatic bit msat(input int i);
    return (i == 1);
  endfunction

  function automatic int lv_of(input int i);
    return (i == 2) ? int'(load_val & 4'd7) : int'(load_val);
  endfunction

  // A step that would leave 0..max is a boundary hit.
  function automatic bit step_hit(input int i, input int q);
    int d;
    d = up_dn ? 1 : -1;
    return en && !load && ((q + d > mx(i)) || (q + d < 0));
  endfunction

  function automatic int step_q(input int i, input int q, input int lv);
    int d;
    int m;
    m = mx(i) + 1;
    if (load) return (lv > mx(i)) ? mx(i) : lv;
    if (!en) return q;
    d = up_dn ? 1 : -1;
    if (msat(i)) begin
      if (q + d > mx(i)) return mx(i);
      if (q + d < 0) return 0;
      return q + d;
    end
    return (q + d + m) % m;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mq[i] <= 0;
        mb[i] <= 0;
        mo[i] <= 0;
      end else begin
        mq[i] <= step_q(i, mq[i], lv_of(i));
        mb[i] <= int'(step_hit(i, mq[i]));
        mo[i] <= int'(step_hit(i, mq[i]) || (mo[i] != 0 && !clr_ovf));
      end
    end
    if (reset) mvalid <= 1'b1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic [31:0] q, input logic [31:0] g,
                     input logic tc, input logic b, input logic o);
    int etc;
    etc = int'(en && (up_dn ? (mq[i] == mx(i)) : (mq[i] == 0)));
    chk($sformatf("model q u%0d", i), q, mq[i]);
    chk($sformatf("model q_gray u%0d", i), g, mq[i] ^ (mq[i] >> 1));
    chk($sformatf("model tc u%0d", i), 32'(tc), etc);
    chk($sformatf("model bnd u%0d", i), 32'(b), mb[i]);
    chk($sformatf("model ovf u%0d", i), 32'(o), mo[i]);
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      cmp(0, 32'(if0.q), 32'(if0.q_gray), if0.tc, if0.bnd, if0.ovf);
      cmp(1, 32'(if1.q), 32'(if1.q_gray), if1.tc, if1.bnd, if1.ovf);
      cmp(2, 32'(if2.q), 32'(if2.q_gray), if2.tc, if2.bnd, if2.ovf);
    end
  end

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic drive(input bit r, input bit e, input bit u, input bit l,
                       input int lv, input bit c);
    reset    = r;
    en       = e;
    up_dn    = u;
    load     = l;
    load_val = 4'(lv);
    clr_ovf  = c;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int exp_q0[12];
  int exp_g2[9];
  int exp_q1[4];
  int exp_b1[4];
  logic [2:0] prev_g;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_val = 4'd0; clr_ovf = 1'b0;
    exp_q0 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    exp_g2 = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
    exp_q1 = '{1, 0, 0, 0};
    exp_b1 = '{0, 0, 1, 1};

    // Reset state.
    drive(1, 0, 1, 0, 0, 0);
    chk("reset q u0", 32'(if0.q), 0);
    chk("reset q_gray u2", 32'(if2.q_gray), 0);
    chk("reset bnd u0", 32'(if0.bnd), 0);
    chk("reset ovf u1", 32'(if1.ovf), 0);

    // Wrap up through MAX_COUNT; Gray sequence on the 3-bit full-range counter.
    prev_g = 3'd0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 1, 0, 0, 0);
      chk("wrap q", 32'(if0.q), exp_q0[k]);
      chk("wrap tc", 32'(if0.tc), int'(exp_q0[k] == 9));
      chk("wrap bnd", 32'(if0.bnd), int'(k == 9));
      chk("wrap ovf", 32'(if0.ovf), int'(k >= 9));
      if (k < 9) begin
        chk("gray seq", 32'(if2.q_gray), exp_g2[k]);
        chk("gray one-bit", $countones(if2.q_gray ^ prev_g), 1);
        prev_g = if2.q_gray;
      end
    end

    // Clear ovf, then saturate down from a load of 2.
    drive(0, 0, 1, 0, 0, 1);
    chk("clr ovf u0", 32'(if0.ovf), 0);
    chk("clr ovf u1", 32'(if1.ovf), 0);
    drive(0, 0, 0, 1, 2, 0);
    chk("load 2 u1", 32'(if1.q), 2);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0, 0, 0);
      chk("sat q", 32'(if1.q), exp_q1[k]);
      chk("sat bnd", 32'(if1.bnd), exp_b1[k]);
      chk("sat ovf", 32'(if1.ovf), int'(k >= 2));
    end

    // Load clamp and load-over-count priority, then reset over load.
    drive(0, 0, 1, 0, 0, 1);
    chk("clr ovf again", 32'(if0.ovf), 0);
    drive(0, 1, 1, 1, 13, 0);
    chk("clamp q", 32'(if0.q), 9);
    chk("clamp bnd", 32'(if0.bnd), 0);
    chk("clamp ovf", 32'(if0.ovf), 0);
    drive(1, 0, 1, 1, 5, 0);
    chk("reset beats load", 32'(if0.q), 0);

    // Sticky clear race: a hit in the clear cycle keeps ovf.
    drive(0, 0, 1, 1, 9, 0);
    drive(0, 1, 1, 0, 0, 0);
    chk("race set ovf", 32'(if0.ovf), 1);
    drive(0, 0, 1, 1, 9, 0);
    chk("race q=9", 32'(if0.q), 9);
    drive(0, 1, 1, 0, 0, 1);
    chk("race ovf kept", 32'(if0.ovf), 1);
    chk("race bnd", 32'(if0.bnd), 1);
    drive(0, 0, 1, 0, 0, 1);
    chk("race ovf cleared", 32'(if0.ovf), 0);

    // Mid-count reset.
    drive(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) drive(0, 1, 1, 0, 0, 0);
    chk("pre-reset q", 32'(if0.q), 6);
    drive(1, 1, 1, 0, 0, 0);
    chk("mid reset q", 32'(if0.q), 0);
    chk("mid reset bnd", 32'(if0.bnd), 0);
    chk("mid reset ovf", 32'(if0.ovf), 0);
    drive(0, 1, 1, 0, 0, 0);
    chk("resume q", 32'(if0.q), 1);

    // Randomized phase, checked against the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
